conv_feeder: RTL and testbench

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder.sv | 164 ++++++++++++++++
 tb/tb_conv_feeder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder.sv
// rtl/conv_feeder.sv - FIFO-buffered sample feeder for a 1D-conv PE chain.
// CONV_FEEDER_PAD_EN adds TAPS-1 leading zero beats (PAD state) before streaming.
module conv_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int TAPS        = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_WIDTH   = 8,
  parameter int FLUSH_BEATS = 2 * TAPS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic                  valid_out,
  output logic                  enable_out,
  output logic                  busy,
  output logic                  done
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int BEAT_W = $clog2(FLUSH_BEATS + TAPS + 1);

`ifdef CONV_FEEDER_PAD_EN
  localparam int PAD_BEATS = TAPS - 1;
  typedef enum logic [2:0] {ST_IDLE, ST_PAD, ST_STREAM, ST_FLUSH, ST_DONE} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_STREAM, ST_FLUSH, ST_DONE} state_t;
`endif

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [LEN_WIDTH-1:0]  len_q, acc_q, emit_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic                  valid_q, enable_q, done_q;
  logic                  in_fill, fifo_full, push, pop;

`ifdef CONV_FEEDER_PAD_EN
  assign in_fill = (state_q == ST_PAD) || (state_q == ST_STREAM);
`else
  assign in_fill = (state_q == ST_STREAM);
`endif

  // Readiness deliberately ignores a same-cycle pop so a full FIFO never takes a push.
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign s_ready   = in_fill && !fifo_full && (acc_q < len_q);
  assign push      = s_valid && s_ready;
  assign pop       = (state_q == ST_STREAM) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      emit_q   <= '0;
      beat_q   <= '0;
      x_q      <= '0;
      valid_q  <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        acc_q    <= acc_q + LEN_WIDTH'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          x_q      <= '0;
          valid_q  <= 1'b0;
          enable_q <= 1'b0;
          if (start) begin
            len_q  <= frame_len;
            acc_q  <= '0;
            emit_q <= '0;
            beat_q <= '0;
            if (frame_len == '0)
              state_q <= (FLUSH_BEATS > 0) ? ST_FLUSH : ST_DONE;
            else
`ifdef CONV_FEEDER_PAD_EN
              state_q <= (PAD_BEATS > 0) ? ST_PAD : ST_STREAM;
`else
              state_q <= ST_STREAM;
`endif
          end
        end
`ifdef CONV_FEEDER_PAD_EN
        ST_PAD: begin
          x_q      <= '0;
          valid_q  <= 1'b0;
          enable_q <= 1'b1;
          if (beat_q == BEAT_W'(PAD_BEATS - 1)) begin
            beat_q  <= '0;
            state_q <= ST_STREAM;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
`endif
        ST_STREAM: begin
          if (pop) begin
            x_q      <= mem_q[rd_ptr_q];
            valid_q  <= 1'b1;
            enable_q <= 1'b1;
            emit_q   <= emit_q + LEN_WIDTH'(1);
            if (emit_q + LEN_WIDTH'(1) == len_q)
              state_q <= (FLUSH_BEATS > 0) ? ST_FLUSH : ST_DONE;
          end else begin
            // Empty FIFO stalls the whole chain; x_out keeps the last sample.
            valid_q  <= 1'b0;
            enable_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          x_q      <= '0;
          valid_q  <= 1'b0;
          enable_q <= 1'b1;
          if (beat_q == BEAT_W'(FLUSH_BEATS - 1)) begin
            beat_q  <= '0;
            state_q <= ST_DONE;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        ST_DONE: begin
          x_q      <= '0;
          valid_q  <= 1'b0;
          enable_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x_out      = x_q;
  assign valid_out  = valid_q;
  assign enable_out = enable_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_feeder.sv
// tb/tb_conv_feeder.sv - randomized self-checking bench for conv_feeder.
// Expected beats come from a per-frame schedule of handshake and pop cycles.
module tb_conv_feeder;

  localparam int DW    = 8;
  localparam int TAPS  = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 8;
  localparam int FB    = 2 * TAPS;
`ifdef CONV_FEEDER_PAD_EN
  localparam int PAD = TAPS - 1;
`else
  localparam int PAD = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [DW-1:0] x_out;
  logic          valid_out, enable_out, busy, done;

  int total = 0;
  int bad   = 0;

  conv_feeder #(
    .DATA_WIDTH(DW), .TAPS(TAPS), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW), .FLUSH_BEATS(FB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_len(frame_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .x_out(x_out),
    .valid_out(valid_out), .enable_out(enable_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_x"}, 32'(x_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_enable"}, 32'(enable_out), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; leaves it idle one cycle after done.
  task automatic run_frame(input int len, input int pct, input int base, input int gap,
                           input bit inject);
    int            pop_at[$];
    logic [DW-1:0] dat[$];
    int            acc, last_p, lend, dcyc, hs, gap_left, occ, p;
    bit            known, fin, ev, ee, ed, rdy;
    logic [DW-1:0] ex, held;

    chk_quiet("idle");
    start = 1'b1;
    frame_len = LW'(len);
    s_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    acc = 0; last_p = 0; hs = 0; gap_left = 0; held = '0; fin = 1'b0;
    known = (len == 0);
    lend = 1;
    dcyc = FB + 2;

    for (int t = 1; t <= 2000; t++) begin
      ev = 1'b0; ee = 1'b0; ed = 1'b0; ex = held;
      if (known && t == dcyc) begin
        ed = 1'b1; ex = '0;
      end else if (known && t > lend && t <= lend + FB) begin
        ee = 1'b1; ex = '0;
      end else begin
        for (int i = 0; i < pop_at.size(); i++)
          if (pop_at[i] + 1 == t) begin
            ev = 1'b1; ee = 1'b1; ex = dat[i]; held = dat[i];
          end
        if (!ev && t >= 2 && t <= 1 + PAD) begin
          ee = 1'b1; ex = '0;
        end
      end
      chk("x_out", 32'(x_out), 32'(ex));
      chk("valid_out", 32'(valid_out), 32'(ev));
      chk("enable_out", 32'(enable_out), 32'(ee));
      chk("done", 32'(done), 32'(ed));
      chk("busy", 32'(busy), 32'(!ed));
      if (ed) begin
        chk("ready_at_done", 32'(s_ready), 32'd0);
        fin = 1'b1;
        break;
      end

      occ = acc;
      foreach (pop_at[i]) if (pop_at[i] < t) occ--;
      rdy = (acc < len) && (occ < DEPTH);

      start = inject && ($urandom_range(0, 3) == 0);
      frame_len = LW'($urandom);
      if (gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
      end else begin
        s_valid = ($urandom_range(1, 100) <= pct);
      end
      s_data = (base >= 0) ? DW'(base + acc) : DW'($urandom);
      #1;
      chk("s_ready", 32'(s_ready), 32'(rdy));
      if (s_valid && s_ready) hs++;
      if (s_valid && rdy) begin
        p = t + 1;
        if (last_p + 1 > p) p = last_p + 1;
        if (1 + PAD > p) p = 1 + PAD;
        pop_at.push_back(p);
        dat.push_back(s_data);
        last_p = p;
        acc++;
        if (gap > 0 && acc == 1) gap_left = gap;
        if (acc == len) begin
          known = 1'b1;
          lend = p + 1;
          dcyc = lend + FB + 1;
        end
      end
      @(posedge clk); @(negedge clk);
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("frame_end_reached", 32'(fin), 32'd1);
    chk("handshakes", 32'(hs), 32'(len));
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int seen;
    #1;
    chk_quiet("in_reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    run_frame(3, 100, 5, 0, 1'b0);
    run_frame(2, 100, 1, 3, 1'b0);
    run_frame(10, 100, -1, 0, 1'b0);
    run_frame(0, 100, -1, 0, 1'b0);
    run_frame(2, 100, -1, 0, 1'b1);
    run_frame(255, 100, -1, 0, 1'b1);
    for (int k = 0; k < 25; k++)
      run_frame($urandom_range(0, 12), $urandom_range(20, 100), -1, $urandom_range(0, 2),
                1'b1);

    // Mid-frame reset after two samples have left the feeder.
    start = 1'b1;
    frame_len = LW'(5);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int t = 0; t < 20 && seen < 2; t++) begin
      s_valid = 1'b1;
      s_data = DW'(8'h40 + t);
      @(posedge clk); @(negedge clk);
      if (valid_out) seen++;
    end
    chk("rst_two_emitted", 32'(seen), 32'd2);
    s_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_quiet("mid_reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); @(negedge clk);
      chk("no_done_after_reset", 32'(done), 32'd0);
    end
    run_frame(1, 100, -1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
